// File: rtl/mem_arbiter.sv
// Memory arbiter between a CPU and a front panel sharing one single-port RAM.
//
// Ports:
//   CLK, RESET             clock and asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU access request, held until cpu_ack
//   cpu_idle               CPU at an instruction boundary or halted
//   cpu_ack, cpu_rdata     one-cycle completion pulse and read data
//   cpu_hold               stalls the CPU sequencer while the panel owns the RAM
//   pnl_req/cmd/wdata      panel request: 01 LDA, 10 DEP, 11 EXM, 00 no-op
//   pnl_ack, pnl_rdata     one-cycle completion pulse and last examined word
//   pnl_ar                 panel address register
//   ram_addr/wdata/we/oe   RAM strobes, one cycle per access
//   ram_rdata              RAM read data, valid the cycle after ram_oe
//
// The panel wins over the CPU, but only while the CPU is idle. All RAM strobes and
// acks are registered, so every access drives the RAM from values captured at the
// moment the request was accepted.
module mem_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  input  logic        cpu_idle,
  output logic        cpu_ack,
  output logic [11:0] cpu_rdata,
  output logic        cpu_hold,
  input  logic        pnl_req,
  input  logic [1:0]  pnl_cmd,
  input  logic [11:0] pnl_wdata,
  output logic        pnl_ack,
  output logic [11:0] pnl_rdata,
  output logic [11:0] pnl_ar,
  output logic [11:0] ram_addr,
  output logic [11:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_oe,
  input  logic [11:0] ram_rdata
);

  localparam logic [1:0] CmdNop = 2'b00;
  localparam logic [1:0] CmdLda = 2'b01;
  localparam logic [1:0] CmdDep = 2'b10;
  localparam logic [1:0] CmdExm = 2'b11;

  typedef enum logic [2:0] {StIdle, StCAcc, StCAck, StPAcc, StPAck} state_e;

  state_e      state_q;
  logic        we_q;
  logic [1:0]  cmd_q;
  logic [11:0] pwdata_q;
  logic        hold_q;
  logic        pnl_go;
  logic        pnl_ram;

  // Panel may only take the RAM at a CPU instruction boundary.
  assign pnl_go  = pnl_req & cpu_idle;
  assign pnl_ram = (pnl_cmd == CmdDep) || (pnl_cmd == CmdExm);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      cmd_q     <= CmdNop;
      pwdata_q  <= '0;
      hold_q    <= 1'b0;
      cpu_ack   <= 1'b0;
      pnl_ack   <= 1'b0;
      pnl_rdata <= '0;
      pnl_ar    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
    end else begin
      // Strobes and acks are single-cycle unless a state re-asserts them.
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      pnl_ack   <= 1'b0;
      hold_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pnl_go) begin
            cmd_q    <= pnl_cmd;
            pwdata_q <= pnl_wdata;
            hold_q   <= 1'b1;
            if (pnl_ram) begin
              state_q  <= StPAcc;
              ram_addr <= pnl_ar;
              ram_we   <= (pnl_cmd == CmdDep);
              ram_oe   <= (pnl_cmd == CmdExm);
              if (pnl_cmd == CmdDep) begin
                ram_wdata <= pnl_wdata;
              end
            end else begin
              // LDA and no-op need no RAM cycle: ack on the next cycle.
              state_q <= StPAck;
              pnl_ack <= 1'b1;
            end
          end else if (cpu_req) begin
            state_q   <= StCAcc;
            we_q      <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
            ram_we    <= cpu_we;
            ram_oe    <= ~cpu_we;
          end
        end
        StCAcc: begin
          state_q <= StCAck;
          cpu_ack <= 1'b1;
        end
        StCAck: begin
          state_q <= StIdle;
        end
        StPAcc: begin
          state_q <= StPAck;
          pnl_ack <= 1'b1;
          hold_q  <= 1'b1;
        end
        StPAck: begin
          state_q <= StIdle;
          case (cmd_q)
            CmdLda: pnl_ar <= pwdata_q;
            CmdDep: pnl_ar <= pnl_ar + 12'd1;
            CmdExm: begin
              pnl_ar    <= pnl_ar + 12'd1;
              pnl_rdata <= ram_rdata;
            end
            default: ;
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM read data arrives during C_ACK, one cycle after ram_oe.
  assign cpu_rdata = (cpu_ack && !we_q) ? ram_rdata : 12'd0;

  // Combinational part asserts the stall in the very cycle the panel is granted.
  assign cpu_hold = hold_q | ((state_q == StIdle) & pnl_go & ~RESET);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [1:0] OpCw  = 2'd0;
  localparam logic [1:0] OpCr  = 2'd1;
  localparam logic [1:0] OpPnl = 2'd2;
  localparam logic [1:0] Nop   = 2'b00;
  localparam logic [1:0] Lda   = 2'b01;
  localparam logic [1:0] Dep   = 2'b10;
  localparam logic [1:0] Exm   = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  cmd;
    logic [11:0] addr;
    logic [11:0] wdata;
    int          lat;
    logic [11:0] exp_rd;
    logic [11:0] exp_ar;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic        cpu_idle = 1'b0;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  logic        cpu_hold;
  logic        pnl_req = 1'b0;
  logic [1:0]  pnl_cmd = 2'b00;
  logic [11:0] pnl_wdata = '0;
  logic        pnl_ack;
  logic [11:0] pnl_rdata;
  logic [11:0] pnl_ar;
  logic [11:0] ram_addr;
  logic [11:0] ram_wdata;
  logic        ram_we;
  logic        ram_oe;
  logic [11:0] ram_rdata = '0;

  logic [11:0] mem [4096];
  logic [64:0] all_out;

  int n_vec = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int oe_cnt = 0;
  logic we_prev = 1'b0;
  logic oe_prev = 1'b0;

  vec_t        tbl [17];
  logic [11:0] sh [8];
  logic [11:0] p_ar;
  logic [11:0] p_rd;

  mem_arbiter dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_idle  (cpu_idle),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_hold  (cpu_hold),
    .pnl_req   (pnl_req),
    .pnl_cmd   (pnl_cmd),
    .pnl_wdata (pnl_wdata),
    .pnl_ack   (pnl_ack),
    .pnl_rdata (pnl_rdata),
    .pnl_ar    (pnl_ar),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_rdata (ram_rdata)
  );

  always #5 CLK = ~CLK;

  assign all_out = {cpu_ack, cpu_rdata, cpu_hold, pnl_ack, pnl_rdata, pnl_ar,
                    ram_addr, ram_wdata, ram_we, ram_oe};

  // Synchronous RAM: registered read data appears the cycle after ram_oe.
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_oe) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle protocol checks.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (ram_we) we_cnt++;
      if (ram_oe) oe_cnt++;
      chk("we_oe_exclusive", 80'(ram_we & ram_oe), 80'(0));
      chk("ack_exclusive", 80'(cpu_ack & pnl_ack), 80'(0));
      chk("strobe_one_cycle", 80'((ram_we & we_prev) | (ram_oe & oe_prev)), 80'(0));
      we_prev = ram_we;
      oe_prev = ram_oe;
    end
  end

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] cmd,
                              input logic [11:0] addr, input logic [11:0] wdata,
                              input int lat, input logic [11:0] rd, input logic [11:0] ar);
    vec_t v;
    v.op = op; v.cmd = cmd; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.exp_rd = rd; v.exp_ar = ar;
    return v;
  endfunction

  task automatic run(input int idx, input vec_t v, input bit now);
    int cyc;
    bit got;
    bit got_cpu;
    bit is_cpu;
    logic [11:0] rd;
    int we0;
    int oe0;
    int exp_we;
    int exp_oe;
    is_cpu = (v.op != OpPnl);
    if (!now) @(negedge CLK);
    we0 = we_cnt;
    oe0 = oe_cnt;
    cpu_idle = 1'b1;
    if (is_cpu) begin
      cpu_req = 1'b1; cpu_we = (v.op == OpCw); cpu_addr = v.addr; cpu_wdata = v.wdata;
    end else begin
      pnl_req = 1'b1; pnl_cmd = v.cmd; pnl_wdata = v.wdata;
    end
    cyc = 0; got = 1'b0; got_cpu = 1'b0; rd = '0;
    while (!got && cyc < 8) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (cpu_ack || pnl_ack) begin
        got = 1'b1; got_cpu = cpu_ack; rd = cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    pnl_req = 1'b0;
    chk($sformatf("v%0d latency", idx), 80'(got ? cyc : 99), 80'(v.lat));
    chk($sformatf("v%0d ack source", idx), 80'(got_cpu), 80'(is_cpu));
    if (v.op == OpCr) chk($sformatf("v%0d cpu_rdata", idx), 80'(rd), 80'(v.exp_rd));
    @(posedge CLK);
    #1;
    if (!is_cpu) begin
      chk($sformatf("v%0d pnl_ar", idx), 80'(pnl_ar), 80'(v.exp_ar));
      chk($sformatf("v%0d pnl_rdata", idx), 80'(pnl_rdata), 80'(v.exp_rd));
    end
    @(negedge CLK);
    exp_we = (v.op == OpCw || (v.op == OpPnl && v.cmd == Dep)) ? 1 : 0;
    exp_oe = (v.op == OpCr || (v.op == OpPnl && v.cmd == Exm)) ? 1 : 0;
    chk($sformatf("v%0d strobe count", idx), 80'({we_cnt - we0, oe_cnt - oe0}),
        80'({exp_we, exp_oe}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int h;
    bit got;
    bit seen;
    bit bad_p;
    logic [11:0] rd;
    logic [11:0] addr;
    logic [11:0] d;
    int a;
    int r;

    tbl[0]  = mk(OpPnl, Lda, 12'o0000, 12'o0200, 1, 12'o0000, 12'o0200);
    tbl[1]  = mk(OpPnl, Dep, 12'o0000, 12'o1234, 2, 12'o0000, 12'o0201);
    tbl[2]  = mk(OpPnl, Dep, 12'o0000, 12'o5670, 2, 12'o0000, 12'o0202);
    tbl[3]  = mk(OpPnl, Lda, 12'o0000, 12'o0200, 1, 12'o0000, 12'o0200);
    tbl[4]  = mk(OpPnl, Exm, 12'o0000, 12'o0000, 2, 12'o1234, 12'o0201);
    tbl[5]  = mk(OpPnl, Exm, 12'o0000, 12'o0000, 2, 12'o5670, 12'o0202);
    tbl[6]  = mk(OpCw,  Nop, 12'o0100, 12'o7777, 2, 12'o0000, 12'o0000);
    tbl[7]  = mk(OpCr,  Nop, 12'o0100, 12'o0000, 2, 12'o7777, 12'o0000);
    tbl[8]  = mk(OpPnl, Lda, 12'o0000, 12'o7777, 1, 12'o5670, 12'o7777);
    tbl[9]  = mk(OpPnl, Dep, 12'o0000, 12'o0001, 2, 12'o5670, 12'o0000);
    tbl[10] = mk(OpCr,  Nop, 12'o7777, 12'o0000, 2, 12'o0001, 12'o0000);
    tbl[11] = mk(OpPnl, Nop, 12'o0000, 12'o4444, 1, 12'o5670, 12'o0000);
    tbl[12] = mk(OpCr,  Nop, 12'o0200, 12'o0000, 2, 12'o1234, 12'o0000);
    tbl[13] = mk(OpCw,  Nop, 12'o0201, 12'o0055, 2, 12'o0000, 12'o0000);
    tbl[14] = mk(OpPnl, Lda, 12'o0000, 12'o0201, 1, 12'o5670, 12'o0201);
    tbl[15] = mk(OpPnl, Exm, 12'o0000, 12'o0000, 2, 12'o0055, 12'o0202);
    tbl[16] = mk(OpCw,  Nop, 12'o0202, 12'o0707, 2, 12'o0000, 12'o0000);

    // Reset state before any clock edge.
    #2;
    chk("reset outputs", 80'(all_out), 80'(0));
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 17; i++) run(i, tbl[i], 1'b0);

    // Simultaneous requests with the CPU busy: CPU first, panel waits.
    @(negedge CLK);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'o0100;
    pnl_req = 1'b1; pnl_cmd = Exm; pnl_wdata = '0; cpu_idle = 1'b0;
    cyc = 0; got = 1'b0; bad_p = 1'b0; rd = '0;
    while (!got && cyc < 8) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (pnl_ack) bad_p = 1'b1;
      if (cpu_ack) begin
        got = 1'b1; rd = cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    chk("B cpu latency", 80'(got ? cyc : 99), 80'(2));
    chk("B cpu rdata", 80'(rd), 80'(12'o7777));
    chk("B no early pnl_ack", 80'(bad_p), 80'(0));
    repeat (3) begin
      @(posedge CLK);
      #1;
      chk("B panel pending", 80'({pnl_ack, ram_we, ram_oe, cpu_hold}), 80'(0));
    end
    @(negedge CLK);
    cpu_idle = 1'b1;
    #1;
    h = int'(cpu_hold);
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      h += int'(cpu_hold);
      if (pnl_ack) begin
        seen = 1'b1; pnl_req = 1'b0;
      end
    end
    pnl_req = 1'b0;
    chk("B hold cycles", 80'(h), 80'(3));
    chk("B pnl acked", 80'(seen), 80'(1));
    chk("B pnl_rdata", 80'(pnl_rdata), 80'(12'o0707));
    chk("B pnl_ar", 80'(pnl_ar), 80'(12'o0203));

    // Reset in the middle of a DEP access.
    run(100, mk(OpCw, Nop, 12'o0050, 12'o0123, 2, 12'o0000, 12'o0000), 1'b0);
    run(101, mk(OpPnl, Lda, 12'o0000, 12'o0050, 1, 12'o0707, 12'o0050), 1'b0);
    @(negedge CLK);
    pnl_req = 1'b1; pnl_cmd = Dep; pnl_wdata = 12'o7070; cpu_idle = 1'b1;
    @(posedge CLK);
    #1;
    chk("C dep strobe", 80'({ram_we, ram_addr}), 80'({1'b1, 12'o0050}));
    #1;
    RESET = 1'b1;
    #1;
    chk("C async reset outputs", 80'(all_out), 80'(0));
    @(posedge CLK);
    #1;
    chk("C outputs in reset", 80'(all_out), 80'(0));
    @(negedge CLK);
    pnl_req = 1'b0;
    RESET = 1'b0;
    run(102, mk(OpCr, Nop, 12'o0050, 12'o0000, 2, 12'o0123, 12'o0000), 1'b1);
    chk("C pnl_ar cleared", 80'(pnl_ar), 80'(0));
    chk("C pnl_rdata cleared", 80'(pnl_rdata), 80'(0));
    p_ar = '0;
    p_rd = '0;

    // Random mix of CPU and panel traffic against a shadow memory.
    for (int i = 0; i < 8; i++) begin
      sh[i] = 12'($urandom_range(0, 4095));
      run(200 + i, mk(OpCw, Nop, 12'o0300 + 12'(i), sh[i], 2, 12'o0000, 12'o0000), 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 7));
      d = 12'($urandom_range(0, 4095));
      addr = 12'o0300 + 12'(a);
      case (r)
        0: begin
          run(300 + i, mk(OpCw, Nop, addr, d, 2, 12'o0000, 12'o0000), 1'b0);
          sh[a] = d;
        end
        1: run(300 + i, mk(OpCr, Nop, addr, 12'o0000, 2, sh[a], 12'o0000), 1'b0);
        2: begin
          run(300 + i, mk(OpPnl, Lda, 12'o0000, addr, 1, p_rd, addr), 1'b0);
          run(400 + i, mk(OpPnl, Dep, 12'o0000, d, 2, p_rd, addr + 12'd1), 1'b0);
          sh[a] = d;
          p_ar = addr + 12'd1;
        end
        default: begin
          run(300 + i, mk(OpPnl, Lda, 12'o0000, addr, 1, p_rd, addr), 1'b0);
          p_rd = sh[a];
          run(400 + i, mk(OpPnl, Exm, 12'o0000, 12'o0000, 2, p_rd, addr + 12'd1), 1'b0);
          p_ar = addr + 12'd1;
        end
      endcase
    end

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose these ports, clock and reset first (name  direction  width  meaning):
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RESET  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-005 cpu_we  in  1  1 = write, 0 = read.
REQ-006 cpu_addr  in  12  CPU word address.
REQ-007 cpu_wdata  in  12  CPU write data.
REQ-008 cpu_idle  in  1  CPU is at an instruction boundary or halted.
REQ-009 cpu_ack  out  1  one-cycle CPU completion pulse.
REQ-010 cpu_rdata  out  12  CPU read data, valid while cpu_ack is high.
REQ-011 cpu_hold  out  1  stalls the sequencer; CPU must not start the next instruction while high.
REQ-012 pnl_req  in  1  panel request; held high until pnl_ack.
REQ-013 pnl_cmd  in  2  panel command: 01 LDA (load AR), 10 DEP (deposit), 11 EXM (examine), 00 no-op.
REQ-014 pnl_wdata  in  12  switch-register value for LDA and DEP.
REQ-015 pnl_ack  out  1  one-cycle panel completion pulse.
REQ-016 pnl_rdata  out  12  examined word, held until the next EXM completes.
REQ-017 pnl_ar  out  12  panel address register.
REQ-018 ram_addr  out  12  RAM address.
REQ-019 ram_wdata  out  12  RAM write data.
REQ-020 ram_we  out  1  RAM write strobe.
REQ-021 ram_oe  out  1  RAM read enable.
REQ-022 ram_rdata  in  12  RAM read data, valid the cycle after ram_oe.

Function
REQ-023 The FSM SHALL have exactly these states: IDLE, C_ACC, C_ACK, P_ACC, P_ACK.
REQ-024 In IDLE, when pnl_req=1 and cpu_idle=1, the FSM SHALL go to P_ACC, or directly to P_ACK for LDA and no-op; this takes priority over cpu_req.
REQ-025 In IDLE, when cpu_req=1 and the REQ-024 condition is false, the FSM SHALL go to C_ACC.
REQ-026 On every IDLE-to-C_ACC or IDLE-to-P_ACC transition, the request fields (we, addr, wdata, cmd) SHALL be latched; ram_* outputs SHALL be driven only from the latched values.
REQ-027 C_ACC: ram_addr = latched cpu_addr, ram_oe = !we, ram_we = we, ram_wdata = latched cpu_wdata; the next state SHALL be C_ACK.
REQ-028 C_ACK: cpu_ack = 1, cpu_rdata = ram_rdata (reads) or 0 (writes); the next state SHALL be IDLE.
REQ-029 CPU latency SHALL be exactly 2 cycles from the cycle cpu_req is sampled in IDLE to cpu_ack.
REQ-030 P_ACC for DEP: ram_addr = pnl_ar, ram_we = 1, ram_wdata = latched pnl_wdata.
REQ-031 P_ACC for EXM: ram_addr = pnl_ar, ram_oe = 1.
REQ-032 After P_ACC, the next state SHALL be P_ACK.
REQ-033 P_ACK: pnl_ack = 1; the next state SHALL be IDLE.
REQ-034 On the P_ACK edge, DEP and EXM SHALL increment pnl_ar by 1, wrapping modulo 4096 (7777 -> 0000); EXM SHALL also load pnl_rdata from ram_rdata.
REQ-035 LDA SHALL load pnl_ar from pnl_wdata with ack latency 1; no RAM strobe SHALL occur.
REQ-036 A no-op (cmd 00) SHALL be acked with latency 1 and change no state.
REQ-037 cpu_hold SHALL be high combinationally in IDLE when pnl_req & cpu_idle, and high registered throughout P_ACC and P_ACK; it SHALL be low otherwise.
REQ-038 A panel request while cpu_idle=0 SHALL wait indefinitely, with no ack and no RAM activity for the panel.
REQ-039 ram_we and ram_oe SHALL never both be high, and each SHALL be high for at most one cycle per access.
REQ-040 When neither request is active, all ram_* outputs SHALL be 0.
REQ-041 Requesters SHALL drop req in the cycle after ack; a req still high in IDLE SHALL be treated as a new request.
REQ-042 Request-field changes while a request is in service SHALL be ignored.
REQ-043 cpu_ack and pnl_ack SHALL never be high in the same cycle.

Reset
REQ-044 On RESET=1, regardless of clock: state = IDLE; pnl_ar = 0000; pnl_rdata = 0000; every output = 0.
REQ-045 RESET asserted during C_ACC or P_ACC SHALL drop ram_we/ram_oe immediately, issue no ack, and leave pnl_ar unchanged from 0000.
REQ-046 After RESET deasserts, the first request SHALL be sampled on the first rising edge.

Verification
REQ-047 LDA pnl_wdata=0200, DEP 1234, DEP 5670, LDA 0200, EXM, EXM (cpu_idle=1) -> pnl_rdata 1234 then 5670; pnl_ar ends at 0202; one ram_we pulse per DEP.
REQ-048 cpu_req write addr 0100 data 7777, then read addr 0100 -> cpu_ack exactly 2 cycles after each sample; read cpu_rdata = 7777.
REQ-049 cpu_req and pnl_req (EXM) in the same cycle with cpu_idle=0 -> CPU served first; panel stays pending; once cpu_idle=1 the panel wins and cpu_hold is high for 3 cycles.
REQ-050 LDA 7777, DEP 0001 -> pnl_ar wraps to 0000; RAM[7777] = 0001.
REQ-051 RESET pulsed mid-P_ACC of a DEP to 0050 -> no pnl_ack; RAM[0050] unchanged; pnl_ar = 0000; all outputs 0.
REQ-052 Random interleaving of CPU and panel traffic against a RAM model -> checks REQ-039 and REQ-043 every cycle; read data matches the model.
